spi_rx_deser: RTL

Receive-side deserializer for the 16-bit SPI link. It consumes the serial stream produced by the SPI transmit stage (`s_clk`, `spi_cs_l`, serial data bit) and rebuilds 16-bit words MSB-first. Completed words go to the downstream consumer over a valid/ready handshake. Overruns and truncated frames are reported. It sits directly downstream of the SPI transmitter, either in the same clock domain or behind its optional input synchronizers.

---
 rtl/spi_rx_deser.sv | 132 +++++++++++++
 1 files changed

// File: rtl/spi_rx_deser.sv
// SPI receive deserializer: rebuilds MSB-first 16-bit words from the serial stream
// and hands them downstream over valid/ready, flagging overruns and truncated frames.
module spi_rx_deser #(
  parameter int SYNC_STAGES = 2,
  parameter int WORD_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_clk,
  input  logic              spi_cs_l,
  input  logic              sdi,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        bit_cnt,
  output logic              overrun,
  output logic              frame_err,
  input  logic              ovr_clr
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  logic sclk_s, cs_s, sdi_s, sclk_q;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sclk_s = s_clk;
      assign cs_s   = spi_cs_l;
      assign sdi_s  = sdi;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sclk_sr, cs_sr, sdi_sr;
      // Reset to the idle line state so release never looks like an s_clk edge.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sclk_sr <= '1;
          cs_sr   <= '1;
          sdi_sr  <= '0;
        end else begin
          sclk_sr[0] <= s_clk;
          cs_sr[0]   <= spi_cs_l;
          sdi_sr[0]  <= sdi;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sclk_sr[i] <= sclk_sr[i-1];
            cs_sr[i]   <= cs_sr[i-1];
            sdi_sr[i]  <= sdi_sr[i-1];
          end
        end
      end
      assign sclk_s = sclk_sr[SYNC_STAGES-1];
      assign cs_s   = cs_sr[SYNC_STAGES-1];
      assign sdi_s  = sdi_sr[SYNC_STAGES-1];
    end
  endgenerate

  state_t            state_q, state_d;
  logic [WORD_W-2:0] shift_q, shift_d;
  logic [4:0]        cnt_d;
  logic [WORD_W-1:0] new_word;
  logic              samp_edge, word_done, fe_d, load, ovr_evt;

  assign samp_edge = sclk_s & ~sclk_q & ~cs_s;
  assign new_word  = {shift_q, sdi_s};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      sclk_q    <= 1'b1;
      shift_q   <= '0;
      bit_cnt   <= '0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      sclk_q    <= sclk_s;
      shift_q   <= shift_d;
      bit_cnt   <= cnt_d;
      frame_err <= fe_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = bit_cnt;
    fe_d      = 1'b0;
    word_done = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!cs_s) state_d = SHIFT;
      end
      SHIFT: begin
        if (cs_s) begin
          state_d = IDLE;
          shift_d = '0;
          cnt_d   = '0;
          fe_d    = (bit_cnt != '0);
        end else if (samp_edge) begin
          shift_d = new_word[WORD_W-2:0];
          if (bit_cnt == 5'(WORD_W - 1)) begin
            cnt_d     = '0;
            word_done = 1'b1;
          end else begin
            cnt_d = bit_cnt + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A completing word may replace one that is being accepted in the same cycle.
  assign load    = word_done & (~out_valid | out_ready);
  assign ovr_evt = word_done & ~load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        out_data  <= new_word;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (ovr_evt)      overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

endmodule
